// File: rtl/snake_step_engine.sv
// -----------------------------------------------------------------------------
// snake_step_engine
// Advances the snake one cell per game tick by sequencing reads and writes to
// the map RAM. Tracks head/tail coordinates, wraps at map edges, detects
// self-collision, grows on food and reports length and game-over.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_run                 1 = ticks advance, 0 = paused (current step finishes)
//   i_speed               clk cycles per tick (values below 8 act as 8)
//   i_cobra_dir           requested direction: 0 up, 1 down, 2 left, 3 right
//   o_mapa_x/o_mapa_y     RAM cell address, valid in the strobe cycle
//   o_mapa_read           one-cycle read strobe
//   i_mapa_dado_read      read data, valid the cycle after o_mapa_read
//   o_mapa_write          one-cycle write strobe
//   o_mapa_dado_write     write data
//   o_length              current snake length
//   o_food_eaten          one-cycle pulse when the head enters food
//   o_game_over           sticky until reset
//   o_step_done           one-cycle pulse at the end of each step
//
// Cell codes: 0 empty, 1..4 body (dir+1 toward the next segment headward),
// 5 food, 6 head, 7..15 obstacle.
// -----------------------------------------------------------------------------
module snake_step_engine #(
    parameter int unsigned MAPA_WIDTH  = 20,
    parameter int unsigned MAPA_HEIGHT = 15,
    parameter int unsigned COORD_W     = 5,
    parameter int unsigned SPEED_W     = 24,
    parameter int unsigned INIT_X      = 10,
    parameter int unsigned INIT_Y      = 7
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_run,
    input  logic [SPEED_W-1:0]     i_speed,
    input  logic [1:0]             i_cobra_dir,
    output logic [COORD_W-1:0]     o_mapa_x,
    output logic [COORD_W-1:0]     o_mapa_y,
    output logic                   o_mapa_read,
    input  logic [3:0]             i_mapa_dado_read,
    output logic                   o_mapa_write,
    output logic [3:0]             o_mapa_dado_write,
    output logic [2*COORD_W-1:0]   o_length,
    output logic                   o_food_eaten,
    output logic                   o_game_over,
    output logic                   o_step_done
);

    localparam int unsigned        LEN_W      = 2 * COORD_W;
    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(MAPA_HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_HEAD0    = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] X_TAIL0    = COORD_W'(INIT_X - 1);
    localparam logic [COORD_W-1:0] Y_START    = COORD_W'(INIT_Y);
    localparam logic [3:0]         CODE_EMPTY = 4'd0;
    localparam logic [3:0]         CODE_RIGHT = 4'd4;
    localparam logic [3:0]         CODE_FOOD  = 4'd5;
    localparam logic [3:0]         CODE_HEAD  = 4'd6;
    localparam logic [SPEED_W-1:0] SPEED_MIN  = SPEED_W'(8);

    typedef enum logic [3:0] {
        S_INIT_T,
        S_INIT_H,
        S_IDLE,
        S_RD_NEXT,
        S_WAIT_NEXT,
        S_RD_TAIL,
        S_WAIT_TAIL,
        S_WR_TAIL,
        S_WR_OLD,
        S_WR_HEAD,
        S_DONE,
        S_DEAD
    } state_t;

    // One-cell move with edge wrap; the edge is detected by compare so the
    // arithmetic never relies on underflow.
    function automatic logic [2*COORD_W-1:0] f_move(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [1:0]         dir
    );
        logic [COORD_W-1:0] nx;
        logic [COORD_W-1:0] ny;
        nx = x;
        ny = y;
        case (dir)
            2'd0:    ny = (y == '0)    ? Y_MAX : y - COORD_W'(1);
            2'd1:    ny = (y == Y_MAX) ? '0    : y + COORD_W'(1);
            2'd2:    nx = (x == '0)    ? X_MAX : x - COORD_W'(1);
            default: nx = (x == X_MAX) ? '0    : x + COORD_W'(1);
        endcase
        return {nx, ny};
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;

    logic [COORD_W-1:0]   r_head_x, r_head_y;
    logic [COORD_W-1:0]   r_tail_x, r_tail_y;
    logic [COORD_W-1:0]   r_next_x, r_next_y;
    logic [1:0]           r_cur_dir;
    logic [1:0]           r_tail_dir;
    logic                 r_grow;
    logic [LEN_W-1:0]     r_len;
    logic [SPEED_W-1:0]   r_cnt;
    logic                 r_pending;

    logic [COORD_W-1:0]   r_mapa_x, r_mapa_y;
    logic                 r_mapa_read, r_mapa_write;
    logic [3:0]           r_mapa_dado_write;
    logic                 r_food_eaten, r_game_over, r_step_done;

    logic [SPEED_W-1:0]   w_speed_eff;
    logic                 w_cnt_en;
    logic                 w_tick;
    logic                 w_go;
    logic [1:0]           w_dir_sel;
    logic [2*COORD_W-1:0] w_next_xy;
    logic [2*COORD_W-1:0] w_tail_adv;
    logic                 w_is_body;
    logic                 w_hit_tail;

    logic [COORD_W-1:0]   w_x, w_y;
    logic                 w_rd, w_wr;
    logic [3:0]           w_wdata;
    logic                 w_food, w_done;

    // Tick generation and step-request bookkeeping
    always_comb begin
        w_speed_eff = (i_speed < SPEED_MIN) ? SPEED_MIN : i_speed;
        w_cnt_en    = i_run && (r_state != S_DEAD);
        w_tick      = w_cnt_en && (r_cnt >= (w_speed_eff - SPEED_W'(1)));
        w_go        = (r_state == S_IDLE) && (w_tick || r_pending);
    end

    // Direction choice (180-degree reversal rejected by flipping the LSB) and
    // the cell lookups derived from it
    always_comb begin
        w_dir_sel  = (i_cobra_dir == {r_cur_dir[1], ~r_cur_dir[0]}) ? r_cur_dir : i_cobra_dir;
        w_next_xy  = f_move(r_head_x, r_head_y, w_dir_sel);
        w_tail_adv = f_move(r_tail_x, r_tail_y, r_tail_dir);
        w_is_body  = ((i_mapa_dado_read >= 4'd1) && (i_mapa_dado_read <= 4'd4)) ||
                     (i_mapa_dado_read == CODE_HEAD);
        w_hit_tail = (r_next_x == r_tail_x) && (r_next_y == r_tail_y);
    end

    // Next state plus the RAM strobes of the state being entered, so the
    // registered strobe lines up with the state that owns it.
    always_comb begin
        w_state_nxt = r_state;
        w_x         = '0;
        w_y         = '0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_wdata     = CODE_EMPTY;
        w_food      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_INIT_T: begin
                w_state_nxt = S_INIT_H;
                w_wr        = 1'b1;
                w_x         = X_TAIL0;
                w_y         = Y_START;
                w_wdata     = CODE_RIGHT;
            end
            S_INIT_H: begin
                w_state_nxt = S_IDLE;
                w_wr        = 1'b1;
                w_x         = X_HEAD0;
                w_y         = Y_START;
                w_wdata     = CODE_HEAD;
            end
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = S_RD_NEXT;
                    w_rd        = 1'b1;
                    {w_x, w_y}  = w_next_xy;
                end
            end
            S_RD_NEXT: begin
                w_state_nxt = S_WAIT_NEXT;
            end
            S_WAIT_NEXT: begin
                if (i_mapa_dado_read == CODE_FOOD) begin
                    w_state_nxt = S_WR_OLD;
                    w_wr        = 1'b1;
                    w_x         = r_head_x;
                    w_y         = r_head_y;
                    w_wdata     = {2'b00, r_cur_dir} + 4'd1;
                end else if ((i_mapa_dado_read == CODE_EMPTY) || (w_is_body && w_hit_tail)) begin
                    // Entering the tail cell is legal: the tail vacates first.
                    w_state_nxt = S_RD_TAIL;
                    w_rd        = 1'b1;
                    w_x         = r_tail_x;
                    w_y         = r_tail_y;
                end else begin
                    w_state_nxt = S_DEAD;
                end
            end
            S_RD_TAIL: begin
                w_state_nxt = S_WAIT_TAIL;
            end
            S_WAIT_TAIL: begin
                w_state_nxt = S_WR_TAIL;
                w_wr        = 1'b1;
                w_x         = r_tail_x;
                w_y         = r_tail_y;
                w_wdata     = CODE_EMPTY;
            end
            S_WR_TAIL: begin
                w_state_nxt = S_WR_OLD;
                w_wr        = 1'b1;
                w_x         = r_head_x;
                w_y         = r_head_y;
                w_wdata     = {2'b00, r_cur_dir} + 4'd1;
            end
            S_WR_OLD: begin
                w_state_nxt = S_WR_HEAD;
                w_wr        = 1'b1;
                w_x         = r_next_x;
                w_y         = r_next_y;
                w_wdata     = CODE_HEAD;
                w_food      = r_grow;
            end
            S_WR_HEAD: begin
                w_state_nxt = S_DONE;
                w_done      = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_DEAD: begin
                w_state_nxt = S_DEAD;
            end
            default: begin
                w_state_nxt = S_INIT_T;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state           <= S_INIT_T;
            r_mapa_x          <= '0;
            r_mapa_y          <= '0;
            r_mapa_read       <= 1'b0;
            r_mapa_write      <= 1'b0;
            r_mapa_dado_write <= '0;
            r_food_eaten      <= 1'b0;
            r_game_over       <= 1'b0;
            r_step_done       <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_mapa_x          <= w_x;
            r_mapa_y          <= w_y;
            r_mapa_read       <= w_rd;
            r_mapa_write      <= w_wr;
            r_mapa_dado_write <= w_wdata;
            r_food_eaten      <= w_food;
            r_game_over       <= (w_state_nxt == S_DEAD);
            r_step_done       <= w_done;
        end
    end

    // Tick counter; a tick that cannot start a step is held one deep
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_cnt_en) begin
                r_cnt <= w_tick ? '0 : r_cnt + SPEED_W'(1);
            end
            if (w_go) begin
                r_pending <= r_pending && w_tick;
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Snake geometry and length
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head_x   <= X_HEAD0;
            r_head_y   <= Y_START;
            r_tail_x   <= X_TAIL0;
            r_tail_y   <= Y_START;
            r_next_x   <= X_HEAD0;
            r_next_y   <= Y_START;
            r_cur_dir  <= 2'd3;
            r_tail_dir <= 2'd3;
            r_grow     <= 1'b0;
            r_len      <= LEN_W'(2);
        end else begin
            case (r_state)
                S_INIT_T: begin
                    r_head_x  <= X_HEAD0;
                    r_head_y  <= Y_START;
                    r_tail_x  <= X_TAIL0;
                    r_tail_y  <= Y_START;
                    r_cur_dir <= 2'd3;
                    r_len     <= LEN_W'(2);
                end
                S_IDLE: begin
                    if (w_go) begin
                        r_cur_dir              <= w_dir_sel;
                        {r_next_x, r_next_y}   <= w_next_xy;
                    end
                end
                S_WAIT_NEXT: begin
                    r_grow <= (i_mapa_dado_read == CODE_FOOD);
                end
                S_WAIT_TAIL: begin
                    r_tail_dir <= 2'(i_mapa_dado_read - 4'd1);
                end
                S_WR_TAIL: begin
                    {r_tail_x, r_tail_y} <= w_tail_adv;
                end
                S_WR_HEAD: begin
                    r_head_x <= r_next_x;
                    r_head_y <= r_next_y;
                    if (r_grow) begin
                        r_len <= r_len + LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_mapa_x          = r_mapa_x;
    assign o_mapa_y          = r_mapa_y;
    assign o_mapa_read       = r_mapa_read;
    assign o_mapa_write      = r_mapa_write;
    assign o_mapa_dado_write = r_mapa_dado_write;
    assign o_length          = r_len;
    assign o_food_eaten      = r_food_eaten;
    assign o_game_over       = r_game_over;
    assign o_step_done       = r_step_done;

endmodule

// File: tb/tb_snake_step_engine.sv
// -----------------------------------------------------------------------------
// tb_snake_step_engine
// Directed bench for snake_step_engine on a 20x15 map with a behavioural map
// RAM. Logs every RAM strobe and pulse with its cycle number and compares
// against hand-computed moves.
// -----------------------------------------------------------------------------
module tb_snake_step_engine;

    localparam int unsigned CW = 5;
    localparam int unsigned SW = 24;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic [SW-1:0]   speed;
    logic [1:0]      dir;
    logic [CW-1:0]   o_mapa_x, o_mapa_y;
    logic            o_mapa_read, o_mapa_write;
    logic [3:0]      rdata;
    logic [3:0]      o_mapa_dado_write;
    logic [2*CW-1:0] o_length;
    logic            o_food_eaten, o_game_over, o_step_done;

    always #5 clk = ~clk;

    snake_step_engine dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_run             (run),
        .i_speed           (speed),
        .i_cobra_dir       (dir),
        .o_mapa_x          (o_mapa_x),
        .o_mapa_y          (o_mapa_y),
        .o_mapa_read       (o_mapa_read),
        .i_mapa_dado_read  (rdata),
        .o_mapa_write      (o_mapa_write),
        .o_mapa_dado_write (o_mapa_dado_write),
        .o_length          (o_length),
        .o_food_eaten      (o_food_eaten),
        .o_game_over       (o_game_over),
        .o_step_done       (o_step_done)
    );

    // Map RAM: cleared while reset is high, bench can poke cells while idle
    logic [3:0] mem [0:14][0:19];
    logic       poke_en = 1'b0;
    int         poke_x, poke_y;
    logic [3:0] poke_d;

    always @(posedge clk) begin
        if (reset) begin
            for (int yy = 0; yy < 15; yy++)
                for (int xx = 0; xx < 20; xx++)
                    mem[yy][xx] <= 4'd0;
        end else if (poke_en) begin
            mem[poke_y][poke_x] <= poke_d;
        end else if (o_mapa_write) begin
            mem[int'(o_mapa_y)][int'(o_mapa_x)] <= o_mapa_dado_write;
        end
        if (o_mapa_read) rdata <= mem[int'(o_mapa_y)][int'(o_mapa_x)];
    end

    // Event log
    typedef struct {
        int c;
        int x;
        int y;
        int d;
    } acc_t;

    int   cyc = 0;
    acc_t wq[$];
    acc_t rq[$];
    int   dq[$];
    int   fq[$];
    int   go_cyc = -1;
    int   both_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (o_mapa_write) wq.push_back('{cyc, int'(o_mapa_x), int'(o_mapa_y), int'(o_mapa_dado_write)});
        if (o_mapa_read)  rq.push_back('{cyc, int'(o_mapa_x), int'(o_mapa_y), 0});
        if (o_step_done)  dq.push_back(cyc);
        if (o_food_eaten) fq.push_back(cyc);
        if (o_game_over && go_cyc < 0) go_cyc = cyc;
        if (o_mapa_read && o_mapa_write) both_cnt++;
    end

    function automatic int enc(input int x, input int y, input int d);
        return x * 10000 + y * 100 + d;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input int x, input int y, input int d);
        int g;
        g = (idx < wq.size()) ? enc(wq[idx].x, wq[idx].y, wq[idx].d) : -1;
        chk(tag, g, enc(x, y, d));
    endtask

    task automatic chk_rd(input string tag, input int idx, input int x, input int y);
        int g;
        g = (idx < rq.size()) ? enc(rq[idx].x, rq[idx].y, 0) : -1;
        chk(tag, g, enc(x, y, 0));
    endtask

    task automatic clear_log();
        wq.delete();
        rq.delete();
        dq.delete();
        fq.delete();
        go_cyc = -1;
    endtask

    task automatic poke(input int x, input int y, input logic [3:0] d);
        @(negedge clk);
        poke_x  = x;
        poke_y  = y;
        poke_d  = d;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Holds run for 8*n edges from a zeroed counter; returns the first tick cycle
    task automatic fire_ticks(input int n, output int t);
        @(negedge clk);
        run = 1'b1;
        t   = cyc + 7;
        repeat (8 * n) @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n);
        int k;
        k = 0;
        while (dq.size() < n && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, dq.size(), n);
    endtask

    task automatic do_step(input string tag, output int t);
        clear_log();
        fire_ticks(1, t);
        wait_done(tag, 1);
    endtask

    // Reset, confirm quiet outputs, release and confirm the two init writes
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        clear_log();
        repeat (3) @(negedge clk);
        chk({tag, "_rst_strobes"}, wq.size() + rq.size(), 0);
        chk({tag, "_rst_outs"}, {o_mapa_read, o_mapa_write, o_food_eaten, o_game_over, o_step_done}, 0);
        chk({tag, "_rst_addr"}, enc(int'(o_mapa_x), int'(o_mapa_y), int'(o_mapa_dado_write)), 0);
        chk({tag, "_rst_len"}, int'(o_length), 2);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk_wr({tag, "_init_tail"}, 0, 9, 7, 4);
        chk_wr({tag, "_init_head"}, 1, 10, 7, 6);
        chk({tag, "_init_gap"}, (wq.size() >= 2) ? wq[1].c - wq[0].c : -1, 1);
        chk({tag, "_init_cnt"}, wq.size(), 2);
        chk({tag, "_init_len"}, int'(o_length), 2);
        chk({tag, "_init_go"}, int'(o_game_over), 0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        run   = 1'b0;
        speed = SW'(8);
        dir   = 2'd3;

        // A: reset and initial snake
        do_reset("a");

        // B: plain move right
        do_step("b_done", t);
        chk("b_lat", (dq.size() > 0) ? dq[0] : -1, t + 8);
        chk_rd("b_rd_next", 0, 11, 7);
        chk_rd("b_rd_tail", 1, 9, 7);
        chk("b_rd_cyc", (rq.size() > 0) ? rq[0].c : -1, t + 1);
        chk_wr("b_wr_tail", 0, 9, 7, 0);
        chk_wr("b_wr_old", 1, 10, 7, 4);
        chk_wr("b_wr_head", 2, 11, 7, 6);
        chk("b_wr_cyc", (wq.size() > 0) ? wq[0].c : -1, t + 5);

        // C: reverse request ignored, low speed clamped to 8
        speed = SW'(3);
        dir   = 2'd2;
        do_step("c_done", t);
        chk("c_lat", (dq.size() > 0) ? dq[0] : -1, t + 8);
        chk_wr("c_wr_tail", 0, 10, 7, 0);
        chk_wr("c_wr_old", 1, 11, 7, 4);
        chk_wr("c_wr_head", 2, 12, 7, 6);
        speed = SW'(8);
        dir   = 2'd3;

        // D: food grows the snake
        poke(13, 7, 4'd5);
        do_step("d_done", t);
        chk("d_lat", (dq.size() > 0) ? dq[0] : -1, t + 5);
        chk("d_wr_cnt", wq.size(), 2);
        chk_wr("d_wr_old", 0, 12, 7, 4);
        chk_wr("d_wr_head", 1, 13, 7, 6);
        chk("d_food_cyc", (fq.size() > 0) ? fq[0] : -1, t + 4);
        chk("d_food_cnt", fq.size(), 1);
        chk("d_len", int'(o_length), 3);

        // E: tick arriving during DONE is held and starts the next step
        clear_log();
        fire_ticks(2, t);
        wait_done("e_done", 2);
        chk("e_lat0", (dq.size() > 0) ? dq[0] : -1, t + 8);
        chk("e_lat1", (dq.size() > 1) ? dq[1] : -1, t + 17);
        chk_wr("e_head15", 5, 15, 7, 6);
        for (int i = 0; i < 4; i++) do_step("e_run", t);
        do_step("e_wrap_done", t);
        chk_rd("e_wrap_rd", 0, 0, 7);
        chk_wr("e_wrap_tail", 0, 17, 7, 0);
        chk_wr("e_wrap_old", 1, 19, 7, 4);
        chk_wr("e_wrap_head", 2, 0, 7, 6);

        // F: turn up, climb to row 0, wrap to the bottom row
        dir = 2'd0;
        for (int i = 0; i < 7; i++) do_step("f_run", t);
        do_step("f_wrap_done", t);
        chk_rd("f_wrap_rd", 0, 0, 14);
        chk_wr("f_wrap_tail", 0, 0, 2, 0);
        chk_wr("f_wrap_old", 1, 0, 0, 1);
        chk_wr("f_wrap_head", 2, 0, 14, 6);
        chk("f_len", int'(o_length), 3);

        // G: build a length-4 2x2 loop and move into the tail cell
        do_reset("g");
        poke(11, 7, 4'd5);
        dir = 2'd3;
        do_step("g1_done", t);
        poke(11, 8, 4'd5);
        dir = 2'd1;
        do_step("g2_done", t);
        chk("g2_len", int'(o_length), 4);
        dir = 2'd2;
        do_step("g3_done", t);
        chk_wr("g3_tail", 0, 9, 7, 0);
        dir = 2'd0;
        do_step("g4_done", t);
        chk("g4_lat", (dq.size() > 0) ? dq[0] : -1, t + 8);
        chk_wr("g4_tail", 0, 10, 7, 0);
        chk_wr("g4_old", 1, 10, 8, 1);
        chk_wr("g4_head", 2, 10, 7, 6);
        chk("g4_go", int'(o_game_over), 0);
        chk("g4_len", int'(o_length), 4);

        // H: reverse request ignored, body ahead ends the game
        poke(10, 6, 4'd4);
        dir = 2'd1;
        clear_log();
        fire_ticks(1, t);
        for (int k = 0; k < 20 && go_cyc < 0; k++) @(negedge clk);
        chk("h_go_cyc", go_cyc, t + 3);
        chk("h_rd_cnt", rq.size(), 1);
        chk_rd("h_rd_next", 0, 10, 6);
        chk("h_wr_cnt", wq.size(), 0);
        chk("h_done_cnt", dq.size(), 0);
        clear_log();
        fire_ticks(1, t);
        repeat (20) @(negedge clk);
        chk("h_dead_strobes", wq.size() + rq.size() + dq.size(), 0);
        chk("h_dead_go", int'(o_game_over), 1);
        chk("h_dead_len", int'(o_length), 4);

        // I: reset clears game over; reset mid-step aborts the step
        do_reset("i");
        dir = 2'd3;
        clear_log();
        fire_ticks(1, t);
        repeat (3) @(negedge clk);
        chk("i_mid_rd", rq.size(), 2);
        do_reset("i_mid");

        chk("strobe_excl", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_step_engine.md
# snake_step_engine

Parametrised snake movement engine that advances the snake one cell per game tick by sequencing reads and writes to the map RAM. Tracks head and tail coordinates, wraps at map edges, detects self-collision, grows on food and reports length and game-over. Sits between the direction input logic and the map RAM; food placement and rendering live in other blocks.

## Interface
- MAPA_WIDTH, 20, map columns (2..2^COORD_W)
- MAPA_HEIGHT, 15, map rows (2..2^COORD_W)
- COORD_W, 5, coordinate width
- SPEED_W, 24, width of speed input and tick counter
- INIT_X, 10, initial head column (≥1)
- INIT_Y, 7, initial head row
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  1 = ticks advance; 0 = paused (step in progress completes)
- speed  in  SPEED_W  clk cycles per tick; values <8 treated as 8
- cobra_dir  in  2  requested direction: 0 up (y-1), 1 down (y+1), 2 left (x-1), 3 right (x+1)
- mapa_x, mapa_y  out  COORD_W  RAM cell address
- mapa_read  out  1  read strobe, one cycle
- mapa_dado_read  in  4  read data, valid exactly one cycle after mapa_read
- mapa_write  out  1  write strobe, one cycle
- mapa_dado_write  out  4  write data
- length  out  COORD_W*2  current snake length
- food_eaten  out  1  one-cycle pulse when head enters food
- game_over  out  1  sticky until reset
- step_done  out  1  one-cycle pulse at end of each step

## Operation
- Cell codes: 0 empty; 1..4 body, value = dir+1 pointing toward the next segment headward; 5 food; 6 head; 7..15 treated as obstacle.
- States: INIT_T, INIT_H, IDLE, RD_NEXT, WAIT_NEXT, RD_TAIL, WAIT_TAIL, WR_TAIL, WR_OLD, WR_HEAD, DONE, DEAD.
- INIT_T writes code 4 at (INIT_X-1, INIT_Y); INIT_H writes 6 at (INIT_X, INIT_Y); head=(INIT_X,INIT_Y), tail=(INIT_X-1,INIT_Y), cur_dir=3, length=2; then IDLE. Rest of RAM cleared by the RAM owner.
- IDLE: on tick (or pending tick) latch cobra_dir into cur_dir unless it is the 180° reverse of cur_dir (0↔1, 2↔3), in which case keep cur_dir. Compute next = head moved by cur_dir with wrap.
- Wrap: x=0 moving left → MAPA_WIDTH-1; x=MAPA_WIDTH-1 moving right → 0; same for y with MAPA_HEIGHT. Decided by compare before arithmetic, never by detecting underflow.
- RD_NEXT reads next; WAIT_NEXT evaluates data: 5 → grow; 0 → move; 1..4 or 6 → collision unless next==tail (tail vacates, legal move); any other code → collision. Collision → DEAD.
- Move (no grow): RD_TAIL, WAIT_TAIL (capture tail code, direction = code-1), WR_TAIL writes 0 at tail, tail advances one cell with wrap. Then WR_OLD, WR_HEAD.
- Grow: skip tail states; length+1; food_eaten pulses in WR_HEAD cycle.
- WR_OLD writes cur_dir+1 at old head; WR_HEAD writes 6 at next; head=next. DONE pulses step_done → IDLE.
- DEAD: game_over=1, no RAM access, ticks ignored, until reset.

## Timing
- Reset values: mapa_x/y=0, mapa_read=0, mapa_write=0, mapa_dado_write=0, length=2, food_eaten=0, game_over=0, step_done=0, tick counter=0, pending=0; state INIT_T.
- At most one of mapa_read/mapa_write high per cycle; address and data valid in the strobe cycle.
- Tick: counter runs while run=1 and state≠DEAD, resets at speed_eff-1, producing a one-cycle tick. Tick outside IDLE sets one-deep pending; extra ticks are dropped.
- Step latency from tick in IDLE to step_done: move 8 cycles, grow 5 cycles, collision: game_over high 3 cycles after tick.
- cobra_dir sampled only in the IDLE tick cycle.
- reset mid-step aborts immediately; no further RAM strobes until INIT_T.

## Test plan
- After reset: writes (9,7)←4 then (10,7)←6 on consecutive cycles; length=2, game_over=0.
- speed=8, empty map, dir=3: step writes (9,7)←0, (10,7)←4, (11,7)←6; step_done 8 cycles after tick; tail=(10,7).
- Head at (19,7), dir=3: next is (0,7); head at (10,0), dir=0: next is (10,14).
- Food code 5 at next cell: no tail erase, length 2→3, food_eaten one pulse, step_done 5 cycles after tick.
- cobra_dir=2 while moving right: ignored, head still moves right; body code 4 at next cell → game_over=1, no further writes.
- Snake length 4 in a 2×2 loop moving into its tail cell: legal, no game_over.
